// File: rtl/note_pkg.sv
// note_pkg: note encoding, nominal tone periods and the period classifier
package note_pkg;

   localparam logic [1:0] NOTE_NONE = 2'd0;
   localparam logic [1:0] NOTE_CS   = 2'd1;
   localparam logic [1:0] NOTE_DS   = 2'd2;
   localparam logic [1:0] NOTE_FS   = 2'd3;

   localparam int NOM_CS  = 97122;
   localparam int NOM_DS  = 86816;
   localparam int NOM_FS  = 72974;
   localparam int NOM_TOL = 512;

   function automatic logic in_window(input int p, input int nom, input int tol);
      return (p >= nom - tol) && (p <= nom + tol);
   endfunction

   function automatic logic windows_overlap(input int a, input int b, input int tol);
      return ((a > b) ? a - b : b - a) <= 2 * tol;
   endfunction

   function automatic logic [1:0] classify(input int p, input int cs, input int ds,
                                           input int fs, input int tol);
      return in_window(p, cs, tol) ? NOTE_CS :
             in_window(p, ds, tol) ? NOTE_DS :
             in_window(p, fs, tol) ? NOTE_FS : NOTE_NONE;
   endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// tone_edge_sync: two-flop synchronizer plus a one-cycle rising-edge pulse
module tone_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic in_i,
   output logic rise_o
);

   logic s1_q, s2_q, dly_q;

   always_ff @(posedge clk)
      if (rst) {s1_q, s2_q, dly_q} <= '0;
      else     {s1_q, s2_q, dly_q} <= {in_i, s1_q, s2_q};

   assign rise_o = s2_q & ~dly_q;

endmodule

// File: rtl/tone_period_detector.sv
// tone_period_detector: measures the rise-to-rise period of a tone line and
// reports a stable C#/D#/F# note after MATCH_N consecutive matching periods
module tone_period_detector
   import note_pkg::*;
#(
   parameter int PERIOD_CS = NOM_CS,
   parameter int PERIOD_DS = NOM_DS,
   parameter int PERIOD_FS = NOM_FS,
   parameter int TOL       = NOM_TOL,
   parameter int TIMEOUT   = 131072,
   parameter int MATCH_N   = 2,
   parameter int CNT_W     = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tone_in,
   output logic [CNT_W-1:0] period,
   output logic             period_strobe,
   output logic [1:0]       note_id,
   output logic             note_valid,
   output logic             tone_lost
);

   localparam int SW = $clog2(MATCH_N + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   if (windows_overlap(PERIOD_CS, PERIOD_DS, TOL) || windows_overlap(PERIOD_CS, PERIOD_FS, TOL) ||
       windows_overlap(PERIOD_DS, PERIOD_FS, TOL) || TIMEOUT >= 2 ** CNT_W) begin : g_bad_cfg
      $error("tone_period_detector: overlapping note windows or TIMEOUT too wide for CNT_W");
   end

   logic             rise, tmo;
   logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
   logic             armed_q, armed_d, lost_q, lost_d, strobe_q, strobe_d, valid_q, valid_d;
   logic [1:0]       cls_q, cls_d, last_q, last_d, id_q, id_d;
   logic [SW-1:0]    streak_q, streak_d, streak_inc;

   tone_edge_sync u_sync (.clk(clk), .rst(rst), .in_i(tone_in), .rise_o(rise));

   always_comb begin
      tmo        = ~rise && (cnt_q == CNT_MAX);
      streak_inc = (streak_q == SW'(MATCH_N)) ? streak_q : streak_q + 1'b1;
      cnt_d      = rise ? '0 : tmo ? cnt_q : cnt_q + 1'b1;
      period_d   = period_q;
      strobe_d   = rise & armed_q;
      cls_d      = cls_q;
      armed_d    = armed_q | rise;
      lost_d     = lost_q & ~rise;
      valid_d    = valid_q;
      id_d       = id_q;
      streak_d   = streak_q;
      last_d     = last_q;
      if (rise && armed_q) begin
         period_d = cnt_q + 1'b1;
         cls_d    = classify(int'(cnt_q) + 1, PERIOD_CS, PERIOD_DS, PERIOD_FS, TOL);
      end
      // classification from the previous cycle's measurement drives the streak
      if (strobe_q) begin
         streak_d = (cls_q == NOTE_NONE) ? '0 : (cls_q == last_q) ? streak_inc : SW'(1);
         valid_d  = (cls_q != NOTE_NONE && cls_q == last_q) ? valid_q : 1'b0;
         id_d     = (cls_q == NOTE_NONE) ? NOTE_NONE : id_q;
         last_d   = cls_q;
         if (cls_q != NOTE_NONE && streak_d == SW'(MATCH_N)) begin
            valid_d = 1'b1;
            id_d    = cls_q;
         end
      end
      if (tmo) begin
         armed_d  = 1'b0;
         lost_d   = 1'b1;
         valid_d  = 1'b0;
         id_d     = NOTE_NONE;
         streak_d = '0;
         last_d   = NOTE_NONE;
      end
   end

   always_ff @(posedge clk)
      if (rst) begin
         cnt_q    <= '0;
         period_q <= '0;
         armed_q  <= 1'b0;
         lost_q   <= 1'b1;
         strobe_q <= 1'b0;
         valid_q  <= 1'b0;
         cls_q    <= NOTE_NONE;
         last_q   <= NOTE_NONE;
         id_q     <= NOTE_NONE;
         streak_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
         armed_q  <= armed_d;
         lost_q   <= lost_d;
         strobe_q <= strobe_d;
         valid_q  <= valid_d;
         cls_q    <= cls_d;
         last_q   <= last_d;
         id_q     <= id_d;
         streak_q <= streak_d;
      end

   assign period        = period_q;
   assign period_strobe = strobe_q;
   assign note_id       = id_q;
   assign note_valid    = valid_q;
   assign tone_lost     = lost_q;

endmodule

// File: tb/tb_tone_period_detector.sv
// tb_tone_period_detector: scaled-period directed and random tone stimulus checked
// every cycle against an event-level model, plus literal spot checks
module tb_tone_period_detector;

   localparam int PCS = 970, PDS = 868, PFS = 730, TOL = 5, TMO = 1311, MN = 2, W = 11;

   logic         clk = 1'b0, rst = 1'b1, tone_in = 1'b0;
   logic [W-1:0] period;
   logic         period_strobe, note_valid, tone_lost;
   logic [1:0]   note_id;

   int n_cmp = 0, n_err = 0, n_strobe = 0;

   tone_period_detector #(.PERIOD_CS(PCS), .PERIOD_DS(PDS), .PERIOD_FS(PFS), .TOL(TOL),
                          .TIMEOUT(TMO), .MATCH_N(MN), .CNT_W(W)) dut (
      .clk(clk), .rst(rst), .tone_in(tone_in), .period(period), .period_strobe(period_strobe),
      .note_id(note_id), .note_valid(note_valid), .tone_lost(tone_lost));

   always #5 clk = ~clk;

   function automatic int exp_class(int p);
      int nom[3] = '{PCS, PDS, PFS};
      for (int i = 0; i < 3; i++) if (p >= nom[i] - TOL && p <= nom[i] + TOL) return i + 1;
      return 0;
   endfunction

   // event-level model: edges are numbered, a period is the distance between rise edges
   bit [2:0] hist = '0;
   int  n_edge = 0, ref_edge = 0, m_period = 0, m_id = 0, m_cls = 0, m_last = 0, m_streak = 0;
   bit  m_armed = 0, m_lost = 1, m_strobe = 0, m_nv = 0;

   always @(posedge clk) begin
      int  c;
      bit  r;
      n_edge++;
      if (period_strobe) n_strobe++;
      if (rst) begin
         hist = '0; ref_edge = n_edge; m_period = 0; m_id = 0; m_cls = 0; m_last = 0;
         m_streak = 0; m_armed = 0; m_lost = 1; m_strobe = 0; m_nv = 0;
      end else begin
         r = hist[1] && !hist[2];
         hist = {hist[1:0], tone_in};
         c = n_edge - 1 - ref_edge;
         if (c > TMO - 1) c = TMO - 1;
         if (m_strobe) begin
            if (m_cls == 0) begin m_streak = 0; m_nv = 0; m_id = 0; end
            else if (m_cls == m_last) m_streak = (m_streak + 1 > MN) ? MN : m_streak + 1;
            else begin m_streak = 1; m_nv = 0; end
            m_last = m_cls;
            if (m_cls != 0 && m_streak == MN) begin m_nv = 1; m_id = m_cls; end
         end
         m_strobe = 0;
         if (r) begin
            if (m_armed) begin m_period = c + 1; m_strobe = 1; m_cls = exp_class(c + 1); end
            else begin m_armed = 1; m_lost = 0; end
            ref_edge = n_edge;
         end else if (c == TMO - 1) begin
            m_armed = 0; m_lost = 1; m_nv = 0; m_id = 0; m_streak = 0; m_last = 0;
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic wave(int p, int n);
      for (int k = 0; k < n; k++) begin
         tone_in = 1'b1;
         repeat (p / 2) @(negedge clk);
         tone_in = 1'b0;
         repeat (p - p / 2) @(negedge clk);
      end
   endtask

   task automatic chk_note(string nm, int id, int valid);
      chk({nm, ".note_id"}, int'(note_id), id);
      chk({nm, ".note_valid"}, int'(note_valid), valid);
   endtask

   initial begin
      int s0, p, h, kind;
      fork
         forever begin
            @(negedge clk);
            n_cmp++;
            if (period !== W'(m_period) || period_strobe !== m_strobe || note_id !== 2'(m_id) ||
                note_valid !== m_nv || tone_lost !== m_lost) begin
               n_err++;
               if (n_err <= 20)
                  $display("FAIL model t=%0t: got p=%0d s=%b id=%0d v=%b lost=%b, expected p=%0d s=%b id=%0d v=%b lost=%b",
                           $time, period, period_strobe, note_id, note_valid, tone_lost,
                           m_period, m_strobe, m_id, m_nv, m_lost);
            end
         end
      join_none
      repeat (4) @(negedge clk);
      chk("rst.period", int'(period), 0);
      chk("rst.strobe", int'(period_strobe), 0);
      chk_note("rst", 0, 0);
      chk("rst.lost", int'(tone_lost), 1);
      rst = 1'b0;
      // C# acquisition: arm, measure, then validate
      s0 = n_strobe;
      wave(PCS, 1);
      chk("cs1.strobes", n_strobe - s0, 0);
      chk("cs1.lost", int'(tone_lost), 0);
      wave(PCS, 1);
      chk("cs2.strobes", n_strobe - s0, 1);
      chk("cs2.period", int'(period), 970);
      chk("cs2.valid", int'(note_valid), 0);
      wave(PCS, 1);
      chk_note("cs3", 1, 1);
      // F# tolerance edge
      wave(PFS + TOL, 3);
      chk_note("fs_in", 3, 1);
      s0 = n_strobe;
      wave(PFS + TOL + 1, 3);
      chk("fs_out.period", int'(period), 736);
      chk("fs_out.strobes", n_strobe - s0, 3);
      chk_note("fs_out", 0, 0);
      // D# -> F#
      wave(PDS, 3);
      chk_note("ds", 2, 1);
      wave(PFS, 2);
      chk("ds2fs1.valid", int'(note_valid), 0);
      wave(PFS, 1);
      chk_note("ds2fs2", 3, 1);
      // tone lost after valid C#
      wave(PCS, 3);
      chk_note("cs_pre_lost", 1, 1);
      tone_in = 1'b1;
      repeat (485) @(negedge clk);
      tone_in = 1'b0;
      repeat (TMO + 2 - 485) @(negedge clk);
      chk("lost.early", int'(tone_lost), 0);
      chk("lost.early_valid", int'(note_valid), 1);
      @(negedge clk);
      chk("lost.now", int'(tone_lost), 1);
      chk_note("lost", 0, 0);
      chk("lost.period", int'(period), 970);
      repeat (50) @(negedge clk);
      s0 = n_strobe;
      wave(PCS, 1);
      chk("rearm.strobes", n_strobe - s0, 0);
      chk("rearm.lost", int'(tone_lost), 0);
      wave(PCS, 1);
      chk("rearm2.strobes", n_strobe - s0, 1);
      chk("rearm2.valid", int'(note_valid), 0);
      // out of band
      s0 = n_strobe;
      wave(500, 3);
      chk("oob.strobes", n_strobe - s0, 3);
      chk("oob.period", int'(period), 500);
      chk_note("oob", 0, 0);
      // reset mid-period during valid D#
      wave(PDS, 3);
      chk_note("ds_pre_rst", 2, 1);
      tone_in = 1'b1;
      repeat (PDS / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst.period", int'(period), 0);
      chk_note("mrst", 0, 0);
      chk("mrst.lost", int'(tone_lost), 1);
      repeat (PDS - PDS / 2 - 101) @(negedge clk);
      s0 = n_strobe;
      wave(PDS, 1);
      chk("mrst1.strobes", n_strobe - s0, 0);
      wave(PDS, 1);
      chk("mrst2.strobes", n_strobe - s0, 1);
      chk("mrst2.period", int'(period), 868);
      // randomized mix of near-nominal, out-of-band, dropouts and resets
      for (int i = 0; i < 28; i++) begin
         kind = $urandom_range(0, 9);
         case ($urandom_range(0, 2))
            0:       p = PCS;
            1:       p = PDS;
            default: p = PFS;
         endcase
         p = ($urandom_range(0, 1) != 0) ? p + $urandom_range(0, TOL + 2) : p - $urandom_range(0, TOL + 2);
         if (kind >= 6 && kind <= 7) p = $urandom_range(100, 1300);
         if (kind == 8) p = $urandom_range(TMO + 20, TMO + 300);
         h = $urandom_range(1, p - 1);
         tone_in = 1'b1;
         repeat (h) @(negedge clk);
         tone_in = 1'b0;
         if (kind == 9) begin
            repeat ((p - h) / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (p - h - (p - h) / 2 - 1) @(negedge clk);
         end else repeat (p - h) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
